neuron_mac_stage: RTL and testbench
===================================

Name: neuron_mac_stage

Overview:
- Per-neuron multiply-accumulate stage that sits directly upstream of the activation lookup ROM.
- Streams NUM_INPUTS signed fixed-point activations and multiplies each by a locally stored weight. Sums the products with saturation, then adds a bias.
- Rescales and saturates the sum to the ACT_IN_WIDTH signed value that addresses the activation ROM.
- Holds that value stable with a one-cycle valid pulse.

Parameters:
- NUM_INPUTS, 784, number of input activations (and weights) per neuron; must be >= 2
- DATA_WIDTH, 16, width of input, weight, bias and internal Q-format word
- FRAC_BITS, 12, fractional bits of the DATA_WIDTH Q format (input, weight, bias)
- ACT_IN_WIDTH, 10, width of activation-ROM address output
- ACT_SHIFT, 6, arithmetic right shift from DATA_WIDTH sum to ACT_IN_WIDTH output

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wt_valid  in  1  weight write strobe
- wt_data  in  DATA_WIDTH  signed weight; auto-increment address
- bias_valid  in  1  bias write strobe
- bias_data  in  DATA_WIDTH  signed bias, FRAC_BITS fraction
- in_valid  in  1  input activation valid
- in_data  in  DATA_WIDTH  signed input activation
- in_ready  out  1  stage accepts in_data this cycle
- out_x  out  ACT_IN_WIDTH  signed activation-ROM input, held until next result
- out_valid  out  1  one-cycle pulse, out_x updated this cycle

Behaviour:
- Reset (rst high at posedge): state IDLE; out_x=0, out_valid=0, in_ready=0; input counter, weight write pointer and accumulator cleared. Bias and weight RAM contents are NOT cleared.
- Weight load: in IDLE, each wt_valid cycle writes wt_data to RAM[wptr], then wptr++. After NUM_INPUTS-1 it wraps to 0. wt_valid outside IDLE is ignored.
- Bias: bias_valid in IDLE latches bias_data. Ignored in other states.
- Loading is complete once wptr has wrapped at least once since reset. in_ready=1 only in ACC.
- FSM states:
  - IDLE: go to ACC when loading is complete and bias has been written since reset. Go on the next cycle, and stay there after every result.
  - ACC: each cycle with in_valid & in_ready accepts one sample and increments the counter. When the NUM_INPUTS-th sample is accepted, in_ready drops the next cycle and the FSM moves to DRAIN.
  - DRAIN: wait 2 cycles for the pipeline to empty.
  - BIAS: add bias, rescale, register out_x, pulse out_valid. Return to ACC and clear the accumulator and counter.
- Pipeline: accept at t; weight RAM read plus input register at t+1; signed product (2*DATA_WIDTH) registered at t+2; accumulator updated at t+3. For the last sample, out_valid is at t+4.
- Arithmetic:
  - Product is shifted >>> FRAC_BITS, then added to a DATA_WIDTH+8 bit accumulator.
  - The sum is saturated to the DATA_WIDTH signed range, and the bias is added with saturation to the same range (s).
  - out_x = s >>> ACT_SHIFT, saturated to the ACT_IN_WIDTH signed range. Positive saturation is 2^(ACT_IN_WIDTH-1)-1, negative is -2^(ACT_IN_WIDTH-1).
- Gaps: in_valid low cycles in ACC stall without effect.
- Mid-operation reset: rst during ACC, DRAIN or BIAS aborts the frame, and no out_valid is produced. The FSM re-enters ACC only after the wptr-wrapped and bias-written conditions are met again; both conditions are cleared by reset.
- out_x is stable between pulses, because the downstream ROM samples it on a later clk.

Optional Feature:
- Macro NEURON_MAC_SAT_FLAG_EN.
- Defined: adds output port sat_flag (1 bit), reset to 0. Updated together with out_valid: it is 1 if any saturation occurred during that frame (accumulator, bias add, or output clamp), else 0.
- Undefined: port absent, no saturation-tracking logic.

Test Plan:
- Default parameters, NUM_INPUTS=4 override. Load weights 1.0 (0x1000) x4, bias 0, inputs 0.25 (0x0400) x4 -> sum 1.0=0x1000; out_x=0x1000>>>6=64; out_valid 4 cycles after last accepted input.
- Same setup, bias=-2.0 (0xE000) -> s=-1.0 (0xF000); out_x=-64 (10'h3C0).
- NUM_INPUTS=4, weights 7.0 (0x7000), inputs 7.0 -> s saturates to 0x7FFF; out_x=511. With NEURON_MAC_SAT_FLAG_EN, sat_flag=1.
- in_valid toggling 1/0 every cycle over one frame -> same out_x as the contiguous case; exactly one out_valid pulse; in_ready low from the cycle after the 4th accept until one cycle after out_valid.
- rst asserted after 2 of 4 inputs -> no out_valid; out_x=0; in_ready=0 until weights (4 writes) and bias are reloaded. The next frame then gives the correct result.
- Back-to-back frames (inputs 0.25 then 0.5, weights 1.0) -> out_x 64 then 128; accumulator does not carry over between frames.

Source files
------------

// File: rtl/neuron_mac_stage.sv
// neuron_mac_stage: streaming weight*input MAC with bias add and rescale to activation-ROM address.
// Optional NEURON_MAC_SAT_FLAG_EN adds a per-frame saturation flag output.
module neuron_mac_stage #(
    parameter int NUM_INPUTS   = 784,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 12,
    parameter int ACT_IN_WIDTH = 10,
    parameter int ACT_SHIFT    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wt_valid,
    input  logic [DATA_WIDTH-1:0]   wt_data,
    input  logic                    bias_valid,
    input  logic [DATA_WIDTH-1:0]   bias_data,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic [ACT_IN_WIDTH-1:0] out_x,
`ifdef NEURON_MAC_SAT_FLAG_EN
    output logic                    sat_flag,
`endif
    output logic                    out_valid
);
    localparam int DW  = DATA_WIDTH;
    localparam int AIW = ACT_IN_WIDTH;
    localparam int AW  = DW + 8;
    localparam int SW  = 2 * DW + 2;
    localparam int CW  = $clog2(NUM_INPUTS + 1);
    localparam int PW  = $clog2(NUM_INPUTS);
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, BIAS} state_t;
    state_t st, nx;
    logic [DW-1:0] ram [NUM_INPUTS];
    logic [PW-1:0] wptr, a1;
    logic [CW-1:0] cnt;
    logic wrapped, bias_ok, dcnt, v1, v2, v3, accept;
    logic signed [DW-1:0] bias, x1, x2, w2, s1, s, sh;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0] acc, acc_nx;
    logic signed [SW-1:0] asum;
    logic signed [DW:0] bsum;
    logic [AIW-1:0] ox;
    logic a_ovf, s1_ovf, b_ovf, o_ovf;
    // Every clamp checks that the discarded high bits are pure sign extension.
    always_comb begin
        accept = in_valid && in_ready;
        asum   = SW'(acc) + SW'(prod >>> FRAC_BITS);
        a_ovf  = !(&asum[SW-1:AW-1] || ~|asum[SW-1:AW-1]);
        acc_nx = a_ovf ? {asum[SW-1], {(AW-1){~asum[SW-1]}}} : asum[AW-1:0];
        s1_ovf = !(&acc[AW-1:DW-1] || ~|acc[AW-1:DW-1]);
        s1     = s1_ovf ? {acc[AW-1], {(DW-1){~acc[AW-1]}}} : acc[DW-1:0];
        bsum   = {s1[DW-1], s1} + {bias[DW-1], bias};
        b_ovf  = bsum[DW] != bsum[DW-1];
        s      = b_ovf ? {bsum[DW], {(DW-1){~bsum[DW]}}} : bsum[DW-1:0];
        sh     = s >>> ACT_SHIFT;
        o_ovf  = !(&sh[DW-1:AIW-1] || ~|sh[DW-1:AIW-1]);
        ox     = o_ovf ? {sh[DW-1], {(AIW-1){~sh[DW-1]}}} : sh[AIW-1:0];
    end
    always_comb begin
        nx = st;
        unique case (st)
            IDLE:  nx = (wrapped && bias_ok) ? ACC : IDLE;
            ACC:   nx = (cnt == CW'(NUM_INPUTS)) ? DRAIN : ACC;
            DRAIN: nx = dcnt ? BIAS : DRAIN;
            BIAS:  nx = ACC;
        endcase
    end
    // Ready stays low through the result pulse so a new frame starts from a cleared accumulator.
    always_comb in_ready = (st == ACC) && (cnt != CW'(NUM_INPUTS)) && !out_valid;
    always_ff @(posedge clk) begin
        if (!rst && st == IDLE && wt_valid) ram[wptr] <= wt_data;
        if (accept) begin
            x1 <= in_data;
            a1 <= cnt[PW-1:0];
        end
        x2   <= x1;
        w2   <= ram[a1];
        prod <= x2 * w2;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            wptr      <= '0;
            wrapped   <= 1'b0;
            bias_ok   <= 1'b0;
            cnt       <= '0;
            dcnt      <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            acc       <= '0;
            out_x     <= '0;
            out_valid <= 1'b0;
        end else begin
            st        <= nx;
            out_valid <= 1'b0;
            if (st == IDLE && wt_valid) begin
                wptr    <= (wptr == PW'(NUM_INPUTS - 1)) ? '0 : wptr + 1'b1;
                wrapped <= wrapped || (wptr == PW'(NUM_INPUTS - 1));
            end
            if (st == IDLE && bias_valid) begin
                bias    <= bias_data;
                bias_ok <= 1'b1;
            end
            if (accept) cnt <= cnt + 1'b1;
            v1   <= accept;
            v2   <= v1;
            v3   <= v2;
            dcnt <= (st == DRAIN) && !dcnt;
            if (v3) acc <= acc_nx;
            if (st == BIAS) begin
                out_x     <= ox;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end
        end
    end
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic fsat;
    always_ff @(posedge clk) begin
        if (rst) begin
            fsat     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (v3 && a_ovf) fsat <= 1'b1;
            if (st == BIAS) begin
                sat_flag <= fsat || s1_ovf || b_ovf || o_ovf;
                fsat     <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_neuron_mac_stage.sv
// tb_neuron_mac_stage: table-driven directed checks of neuron_mac_stage with NUM_INPUTS=4.
module tb_neuron_mac_stage;
    localparam int N = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic wt_valid = 1'b0, bias_valid = 1'b0, in_valid = 1'b0;
    logic [15:0] wt_data = '0, bias_data = '0, in_data = '0;
    logic in_ready, out_valid;
    logic [9:0] out_x;
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic sat_flag;
`endif
    int cyc = 0, n_cmp = 0, n_bad = 0;

    neuron_mac_stage #(.NUM_INPUTS(N)) dut (
        .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_data(wt_data),
        .bias_valid(bias_valid), .bias_data(bias_data), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_x(out_x),
`ifdef NEURON_MAC_SAT_FLAG_EN
        .sat_flag(sat_flag),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] w, b, x;
        bit gap;
        int ex;
        bit sat;
    } vec_t;
    vec_t v[9];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; wt_valid = 1'b0; bias_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_w(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wt_valid = 1'b1; wt_data = w;
        end
        @(negedge clk);
        wt_valid = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] b);
        @(negedge clk);
        bias_valid = 1'b1; bias_data = b;
        @(negedge clk);
        bias_valid = 1'b0;
    endtask

    // Drives samples until n are accepted; last = posedge index of the final accept.
    task automatic feed(input logic [15:0] x, input bit gap, input int n, output int got, output int last, output int pulses);
        int k = 0;
        got = 0; last = 0; pulses = 0;
        while (got < n && k < 200) begin
            @(negedge clk);
            if (out_valid) pulses++;
            in_valid = gap ? (k % 2 == 0) : 1'b1;
            in_data  = x;
            if (in_valid && in_ready) begin
                got++;
                last = cyc + 1;
            end
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic frame(input string nm, input logic [15:0] x, input bit gap, input int ex, input bit sat);
        int got, last, pulses, k = 0, rdy_hi = 0;
        logic [9:0] held;
        feed(x, gap, N, got, last, pulses);
        check({nm, " accepts"}, got, N);
        while (!out_valid && k < 20) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
            k++;
        end
        if (in_ready) rdy_hi++;
        check({nm, " latency"}, out_valid ? cyc - last : -1, 4);
        check({nm, " out_x"}, $signed(out_x), ex);
        check({nm, " ready low"}, rdy_hi, 0);
        check({nm, " early pulse"}, pulses, 0);
`ifdef NEURON_MAC_SAT_FLAG_EN
        check({nm, " sat_flag"}, int'(sat_flag), int'(sat));
`endif
        held = out_x;
        @(negedge clk);
        check({nm, " pulse width"}, int'(out_valid), 0);
        check({nm, " ready back"}, int'(in_ready), 1);
        check({nm, " hold"}, int'(out_x), int'(held));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got, last, pulses, bad;
        v[0] = '{16'h1000, 16'h0000, 16'h0400, 1'b0, 64, 1'b0};
        v[1] = '{16'h1000, 16'hE000, 16'h0400, 1'b0, -64, 1'b0};
        v[2] = '{16'h7000, 16'h0000, 16'h7000, 1'b0, 511, 1'b1};
        v[3] = '{16'h1000, 16'h0000, 16'h0400, 1'b1, 64, 1'b0};
        v[4] = '{16'hF000, 16'h0000, 16'h7000, 1'b0, -512, 1'b1};
        v[5] = '{16'h1000, 16'h7000, 16'h1000, 1'b0, 511, 1'b1};
        v[6] = '{16'h2000, 16'h0800, 16'h0C00, 1'b0, 416, 1'b0};
        v[7] = '{16'h1000, 16'h0000, 16'hFFF0, 1'b0, -1, 1'b0};
        v[8] = '{16'h0800, 16'h0040, 16'h0001, 1'b1, 1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            do_reset();
            check($sformatf("v%0d reset out_x", i), int'(out_x), 0);
            check($sformatf("v%0d reset out_valid", i), int'(out_valid), 0);
            check($sformatf("v%0d reset in_ready", i), int'(in_ready), 0);
            load_w(v[i].w, N);
            load_b(v[i].b);
            frame($sformatf("v%0d", i), v[i].x, v[i].gap, v[i].ex, v[i].sat);
        end

        // Abort a frame with reset; no result, and reload is required.
        do_reset();
        load_w(16'h1000, N);
        load_b(16'h0000);
        frame("pre-abort", 16'h0400, 1'b0, 64, 1'b0);
        feed(16'h0400, 1'b0, 2, got, last, pulses);
        check("abort accepts", got, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || in_ready) bad++;
        end
        check("abort quiet", bad, 0);
        check("abort out_x", int'(out_x), 0);
        load_b(16'h0000);
        load_w(16'h1000, N - 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        check("partial load ready", bad, 0);
        load_w(16'h1000, 1);
        frame("post-abort", 16'h0400, 1'b0, 64, 1'b0);

        // Back-to-back frames; writes while running must be ignored.
        do_reset();
        load_w(16'h1000, N);
        load_b(16'h0000);
        frame("b2b first", 16'h0400, 1'b0, 64, 1'b0);
        @(negedge clk);
        wt_valid = 1'b1; wt_data = 16'h7000; bias_valid = 1'b1; bias_data = 16'h7000;
        @(negedge clk);
        wt_valid = 1'b0; bias_valid = 1'b0;
        frame("b2b second", 16'h0800, 1'b0, 128, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
